// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU fault log: register map, STATUS/CTRL bit
// positions, bus FSM encoding and a saturating counter helper.
package mpu_pkg;

  localparam logic [3:0] REG_STATUS    = 4'h0;
  localparam logic [3:0] REG_HEAD_PC   = 4'h4;
  localparam logic [3:0] REG_HEAD_INFO = 4'h8;
  localparam logic [3:0] REG_CTRL      = 4'hC;

  localparam int ST_COUNT_W   = 5;
  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_BIT   = 10;
  localparam int ST_DROP_LSB  = 16;

  localparam int CTRL_POP_BIT     = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;

  localparam int INFO_WR_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RESP = 2'b01,
    ST_HOLD = 2'b10
  } bus_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

endpackage

// File: rtl/mpu_fault_log_if.sv
// CPU register bus for the MPU fault log; the CPU side is the master.
interface mpu_fault_log_if;
  logic        reg_valid;
  logic        reg_ready;
  logic [3:0]  reg_addr;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (output reg_valid, reg_addr, reg_wstrb, reg_wdata,
                  input  reg_ready, reg_rdata);
  modport slave  (input  reg_valid, reg_addr, reg_wstrb, reg_wdata,
                  output reg_ready, reg_rdata);
endinterface

// File: rtl/mpu_fault_fifo.sv
// Fault entry FIFO. A push while full is accepted only together with a pop;
// a pop while empty is ignored, so a simultaneous push on empty still lands.
module mpu_fault_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 55,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_head];
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) r_tail <= r_tail + PTR_W'(1'b1);
      if (w_do_pop)  r_head <= r_head + PTR_W'(1'b1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1'b1);
        2'b01:   r_count <= r_count - CNT_W'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= i_data;
  end

endmodule

// File: rtl/mpu_fault_log.sv
// MPU fault log: captures {pc, wr, addr} on each rising fault_in edge into a
// FIFO and exposes it through a four-register CPU bus with an interrupt.
module mpu_fault_log
  import mpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 22
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fault_in,
  input  logic [31:0]       fault_pc,
  input  logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_wr,
  mpu_fault_log_if.slave    bus,
  output logic              fault_irq
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DATA_W = 33 + ADDR_W;

  logic              r_fault_prev;
  logic              r_cap_vld;
  logic [DATA_W-1:0] r_cap_data;
  bus_state_t        r_state;
  logic              r_ready;
  logic [31:0]       r_rdata;
  logic              r_irq_en;
  logic              r_ovf;
  logic [7:0]        r_drop;
  logic              r_irq;

  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_head;
  logic              w_wr_act;
  logic              w_pop;
  logic              w_clr;
  logic              w_drop;
  logic [31:0]       w_status;
  logic [31:0]       w_info;
  logic [31:0]       w_rd_mux;
  logic              w_unused_wdata;

  assign w_wr_act       = (r_state == ST_RESP) & (bus.reg_wstrb != 4'h0) & (bus.reg_addr == REG_CTRL);
  assign w_pop          = w_wr_act & bus.reg_wdata[CTRL_POP_BIT];
  assign w_clr          = w_wr_act & bus.reg_wdata[CTRL_CLR_OVF_BIT];
  assign w_drop         = r_cap_vld & w_full & ~w_pop;
  assign w_unused_wdata = ^bus.reg_wdata[31:3];
  assign bus.reg_ready  = r_ready;
  assign bus.reg_rdata  = r_rdata;
  assign fault_irq      = r_irq;

  // Edge detect: a held-high fault_in logs once; the push lands a cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fault_prev <= 1'b0;
      r_cap_vld    <= 1'b0;
      r_cap_data   <= {DATA_W{1'b0}};
    end else begin
      r_fault_prev <= fault_in;
      r_cap_vld    <= fault_in & ~r_fault_prev;
      r_cap_data   <= {fault_pc, fault_wr, fault_addr};
    end
  end

  mpu_fault_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (r_cap_vld),
    .i_pop   (w_pop),
    .i_data  (r_cap_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Read data selection; head registers read zero while the FIFO is empty.
  always_comb begin
    w_status = 32'h0;
    w_status[ST_COUNT_W-1:0] = ST_COUNT_W'(w_count);
    w_status[ST_EMPTY_BIT]   = w_empty;
    w_status[ST_FULL_BIT]    = w_full;
    w_status[ST_OVF_BIT]     = r_ovf;
    w_status[ST_DROP_LSB +: 8] = r_drop;
    w_info = 32'h0;
    if (!w_empty) begin
      w_info[INFO_WR_BIT]  = w_head[ADDR_W];
      w_info[ADDR_W-1:0]   = w_head[ADDR_W-1:0];
    end else begin
      w_info = 32'h0;
    end
    w_rd_mux = 32'h0;
    case (bus.reg_addr)
      REG_STATUS:    w_rd_mux = w_status;
      REG_HEAD_PC:   w_rd_mux = w_empty ? 32'h0 : w_head[DATA_W-1 -: 32];
      REG_HEAD_INFO: w_rd_mux = w_info;
      REG_CTRL:      w_rd_mux[CTRL_IRQ_EN_BIT] = r_irq_en;
      default:       w_rd_mux = 32'h0;
    endcase
  end

  // Bus handshake FSM: one ready pulse per request, rearm only after valid drops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b0;
      r_rdata  <= 32'h0;
      r_irq_en <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.reg_valid) begin
            r_state <= ST_RESP;
            r_ready <= 1'b1;
            r_rdata <= w_rd_mux;
          end else begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
          end
        end
        ST_RESP: begin
          r_state <= ST_HOLD;
          r_ready <= 1'b0;
          r_rdata <= 32'h0;
          if (w_wr_act) r_irq_en <= bus.reg_wdata[CTRL_IRQ_EN_BIT];
        end
        ST_HOLD: begin
          r_ready <= 1'b0;
          r_rdata <= 32'h0;
          if (!bus.reg_valid) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_rdata <= 32'h0;
        end
      endcase
    end
  end

  // Overflow flag and drop counter; a drop in the clear cycle still counts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf  <= 1'b0;
      r_drop <= 8'h00;
    end else if (w_drop) begin
      r_ovf  <= 1'b1;
      r_drop <= sat_inc8(r_drop);
    end else if (w_clr) begin
      r_ovf  <= 1'b0;
      r_drop <= 8'h00;
    end
  end

  // Registered interrupt level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_irq <= 1'b0;
    else         r_irq <= r_irq_en & (~w_empty | r_ovf);
  end

endmodule
